pes_rca_pipe: RTL and testbench

//   Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 4-bit RCA.

---
 rtl/pes_rca_pipe.sv | 105 ++++++++++
 tb/tb_pes_rca_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pes_rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES carry-chained
// segments, one register stage each, with valid/ready handshakes on input and output.
module pes_rca_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SEG  = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   logic              w_adv;
   logic [WIDTH-1:0]  w_b_eff;
   logic              w_c0;

   // Stage k register holds the bundle after segment k has been added: untouched operand
   // bits ride along for later segments, finished sum bits ride along for deskew.
   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] r_c;
   logic [WIDTH-1:0]  r_a [STAGES];
   logic [WIDTH-1:0]  r_b [STAGES];
   logic [WIDTH-1:0]  r_s [STAGES];
   logic              r_ovf;

   logic [WIDTH-1:0]  w_a_src [STAGES];
   logic [WIDTH-1:0]  w_b_src [STAGES];
   logic [WIDTH-1:0]  w_s_src [STAGES];
   logic [WIDTH-1:0]  w_s_nxt [STAGES];
   logic [SEG:0]      w_seg   [STAGES];
   logic [STAGES-1:0] w_c_src;
   logic [STAGES-1:0] w_c_nxt;
   logic [STAGES-1:0] w_v_src;
   logic              w_ovf_nxt;

   assign w_adv    = ~r_vld[LAST] | out_ready;
   assign in_ready = w_adv;
   assign w_b_eff  = sub ? ~b : b;
   assign w_c0     = sub | cin;

   always_comb begin
      w_a_src[0] = a;
      w_b_src[0] = w_b_eff;
      w_s_src[0] = '0;
      w_c_src[0] = w_c0;
      w_v_src[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_a_src[k] = r_a[k-1];
         w_b_src[k] = r_b[k-1];
         w_s_src[k] = r_s[k-1];
         w_c_src[k] = r_c[k-1];
         w_v_src[k] = r_vld[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_seg[k] = {1'b0, w_a_src[k][k*SEG +: SEG]} + {1'b0, w_b_src[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, w_c_src[k]};
         w_s_nxt[k] = w_s_src[k];
         w_s_nxt[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
         w_c_nxt[k] = w_seg[k][SEG];
      end
      // a^b^sum at the MSB recovers the carry into the MSB
      w_ovf_nxt = w_a_src[LAST][WIDTH-1] ^ w_b_src[LAST][WIDTH-1]
                ^ w_s_nxt[LAST][WIDTH-1] ^ w_c_nxt[LAST];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_c   <= '0;
         r_ovf <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
      end else if (w_adv) begin
         r_vld <= w_v_src;
         r_c   <= w_c_nxt;
         r_ovf <= w_ovf_nxt;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= w_a_src[k];
            r_b[k] <= w_b_src[k];
            r_s[k] <= w_s_nxt[k];
         end
      end
   end

   assign out_valid = r_vld[LAST];
   assign sum       = r_s[LAST];
   assign cout      = r_c[LAST];
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_pes_rca_pipe.sv
// Bench for pes_rca_pipe: directed scenarios plus random traffic on an 8-bit/2-stage instance
// and an exhaustive sweep on a 4-bit/4-stage instance, scored against an arithmetic model.
module tb_pes_rca_pipe;

   typedef struct {
      int s;
      int co;
      int ov;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [7:0] a, b, sum;
   logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_got4 = 0;
   logic acc4;
   exp_t q8[$];
   exp_t q4[$];

   pes_rca_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf)
   );

   pes_rca_pipe #(.WIDTH(4), .STAGES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
      .cin(cin4), .sub(1'b0), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
      .cout(cout4), .ovf(ovf4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Plain-arithmetic reference: unsigned sum for sum/cout, signed range check for ovf.
   function automatic void model(input int w, input int av, input int bv, input int cv,
                                 input int sv, output int s, output int co, output int ov);
      int mask, half, u, sa, sb, r;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      if (sv != 0) u = av + ((~bv) & mask) + 1;
      else         u = av + bv + cv;
      s  = u & mask;
      co = (u >> w) & 1;
      sa = (av >= half) ? av - (1 << w) : av;
      sb = (bv >= half) ? bv - (1 << w) : bv;
      r  = (sv != 0) ? sa - sb : sa + sb + cv;
      ov = (r >= half || r < -half) ? 1 : 0;
   endfunction

   // Score handshakes at the negedge, then advance one rising edge.
   task automatic tick();
      exp_t e;
      int   s, co, ov;
      @(negedge clk);
      acc4 = 1'b0;
      if (rst) begin
         q8.delete();
         q4.delete();
      end else begin
         chk("in_ready", in_ready, !out_valid || out_ready);
         if (out_valid && out_ready) begin
            chk("sb8_nonempty", q8.size() > 0, 1);
            if (q8.size() > 0) begin
               e = q8.pop_front();
               chk("sum8", sum, e.s);
               chk("cout8", cout, e.co);
               chk("ovf8", ovf, e.ov);
            end
         end
         if (in_valid && in_ready) begin
            model(8, a, b, cin, sub, s, co, ov);
            q8.push_back('{s, co, ov});
         end
         if (out_valid4 && out_ready4) begin
            n_got4++;
            chk("sb4_nonempty", q4.size() > 0, 1);
            if (q4.size() > 0) begin
               e = q4.pop_front();
               chk("sum4", sum4, e.s);
               chk("cout4", cout4, e.co);
               chk("ovf4", ovf4, e.ov);
            end
         end
         if (in_valid4 && in_ready4) begin
            model(4, a4, b4, cin4, 0, s, co, ov);
            q4.push_back('{s, co, ov});
            acc4 = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic sv);
      in_valid = 1'b1;
      a = av; b = bv; cin = cv; sub = sv;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int idx, cyc;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_out_valid4", out_valid4, 0);

      // 1: 80+80, latency of two edges
      send(8'h80, 8'h80, 1'b0, 1'b0);
      chk("t1_not_yet", out_valid, 0);
      tick();
      chk("t1_valid", out_valid, 1);
      chk("t1_sum", sum, 8'h00);
      chk("t1_cout", cout, 1);
      chk("t1_ovf", ovf, 1);
      tick();

      // 2: back-to-back, no gap
      send(8'h0F, 8'h01, 1'b0, 1'b0);
      send(8'hFF, 8'h01, 1'b1, 1'b0);
      chk("t2_valid_a", out_valid, 1);
      chk("t2_sum_a", sum, 8'h10);
      chk("t2_cout_a", cout, 0);
      tick();
      chk("t2_valid_b", out_valid, 1);
      chk("t2_sum_b", sum, 8'h01);
      chk("t2_cout_b", cout, 1);
      tick();

      // 3: subtract ignores cin
      send(8'h05, 8'h07, 1'b1, 1'b1);
      sub = 1'b0;
      tick();
      chk("t3_sum", sum, 8'hFE);
      chk("t3_cout", cout, 0);
      chk("t3_ovf", ovf, 0);
      tick();

      // 4: backpressure with two bundles in flight
      out_ready = 1'b0;
      send(8'h12, 8'h34, 1'b0, 1'b0);
      send(8'h7F, 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("t4_in_ready", in_ready, 0);
         chk("t4_hold_valid", out_valid, 1);
         chk("t4_hold_sum", sum, 8'h46);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("t4_second_valid", out_valid, 1);
      chk("t4_second_sum", sum, 8'h80);
      chk("t4_second_ovf", ovf, 1);
      tick();
      chk("t4_drained", out_valid, 0);

      // 5: reset with bundles in flight
      send(8'h11, 8'h22, 1'b0, 1'b0);
      send(8'h33, 8'h44, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_flushed", out_valid, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_no_stale", out_valid, 0);
      end
      send(8'h01, 8'h02, 1'b0, 1'b0);
      tick();
      chk("t5_new_valid", out_valid, 1);
      chk("t5_new_sum", sum, 8'h03);
      tick();

      // random traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         a         = 8'($urandom);
         b         = 8'($urandom);
         cin       = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q8.size() > 0; i++) tick();
      chk("rand8_drained", q8.size(), 0);

      // 6: exhaustive 4-bit / 4-stage sweep
      idx = 0;
      cyc = 0;
      while (idx < 512 && cyc < 5000) begin
         in_valid4  = 1'b1;
         {a4, b4, cin4} = idx[8:0];
         out_ready4 = 1'($urandom_range(0, 1));
         tick();
         if (acc4) idx++;
         cyc++;
      end
      in_valid4  = 1'b0;
      out_ready4 = 1'b1;
      for (int i = 0; i < 40 && q4.size() > 0; i++) tick();
      chk("t6_accepted", idx, 512);
      chk("t6_results", n_got4, 512);
      chk("t6_drained", q4.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
